// File: rtl/cpu_bp_pkg.sv
// rtl/cpu_bp_pkg.sv - shared counter encodings for the branch predictor
package cpu_bp_pkg;

   localparam logic [1:0] BP_SNT = 2'b00;
   localparam logic [1:0] BP_WNT = 2'b01;
   localparam logic [1:0] BP_WT  = 2'b10;
   localparam logic [1:0] BP_ST  = 2'b11;

   localparam logic [1:0] BP_CTR_INIT  = BP_WNT;
   localparam logic [1:0] BP_CTR_ALLOC = BP_WT;

   // Upper counter bit alone separates the taken half (WT/ST) from the not-taken half.
   function automatic logic bp_predict_taken(input logic [1:0] ctr);
      return ctr[1];
   endfunction

endpackage

// File: rtl/bp_counter_next.sv
// rtl/bp_counter_next.sv - saturating 2-bit branch counter next-state
module bp_counter_next
   import cpu_bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != BP_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - IF-stage BHT/BTB predictor trained from ID resolution
module branch_predict_unit
   import cpu_bp_pkg::*;
#(
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = 26
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        Branch_predict,
   output logic [31:0] nextpc_predicted,
   input  logic        flush_all,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispredict,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int ENTRIES = 2 ** INDEX_BITS;

   logic                  valid_q [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
   logic [1:0]            ctr_q   [ENTRIES];
   logic [31:0]           tgt_q   [ENTRIES];

   logic [INDEX_BITS-1:0] idx;
   logic [INDEX_BITS-1:0] uidx;
   logic [TAG_BITS-1:0]   tag;
   logic [TAG_BITS-1:0]   utag;
   logic                  hit;
   logic                  uhit;
   logic [1:0]            uctr_next;
   logic                  unused_pc_bits;

   assign idx  = pc[INDEX_BITS+1:2];
   assign tag  = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign uidx = upd_pc[INDEX_BITS+1:2];
   assign utag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

   // Instructions are word aligned, so the byte offset never reaches the tables.
   assign unused_pc_bits = ^{pc[1:0], upd_pc[1:0]};

   // Lookup reads the registered tables directly: a same-cycle update is not bypassed.
   assign hit              = valid_q[idx] && (tag_q[idx] == tag);
   assign Branch_predict   = hit && bp_predict_taken(ctr_q[idx]);
   assign nextpc_predicted = Branch_predict ? tgt_q[idx] : pc + 32'd4;

   assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

   bp_counter_next u_ctr_next (
      .ctr      (ctr_q[uidx]),
      .taken    (upd_taken),
      .ctr_next (uctr_next)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            ctr_q[i]   <= BP_CTR_INIT;
            tgt_q[i]   <= '0;
         end
      end else if (flush_all) begin
         // Flush only drops valid bits; counters and targets survive for the next allocation.
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (upd_valid) begin
         if (uhit) begin
            ctr_q[uidx] <= uctr_next;
            if (upd_taken) tgt_q[uidx] <= upd_target;
         end else if (upd_taken) begin
            valid_q[uidx] <= 1'b1;
            tag_q[uidx]   <= utag;
            tgt_q[uidx]   <= upd_target;
            ctr_q[uidx]   <= BP_CTR_ALLOC;
         end
      end
   end

   // Statistics count every resolution, even when a flush suppresses the table write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (upd_valid) begin
         branch_count <= branch_count + 32'd1;
         if (upd_mispredict) mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic        Branch_predict;
   logic [31:0] nextpc_predicted;
   logic        flush_all = 1'b0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_mispredict = 1'b0;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int tests = 0;
   int fails = 0;

   // Reference: per-entry records with counter as an integer strength 0..3.
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   int          m_ctr   [16];
   logic [31:0] m_tgt   [16];
   logic [31:0] m_br;
   logic [31:0] m_mis;

   branch_predict_unit dut (
      .clock            (clock),
      .reset            (reset),
      .pc               (pc),
      .Branch_predict   (Branch_predict),
      .nextpc_predicted (nextpc_predicted),
      .flush_all        (flush_all),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clock = ~clock;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % 32'd16);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return a >> 6;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_ctr[i]   = 1;
         m_tgt[i]   = '0;
      end
      m_br  = '0;
      m_mis = '0;
   endtask

   task automatic model_predict(input logic [31:0] p, output bit bp, output logic [31:0] np);
      int i;
      i  = idx_of(p);
      bp = m_valid[i] && (m_tag[i] == tag_of(p)) && (m_ctr[i] >= 2);
      np = bp ? m_tgt[i] : p + 32'd4;
   endtask

   task automatic model_update(input logic uv, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utg, input logic um, input logic fl);
      int i;
      if (uv) begin
         m_br = m_br + 1;
         if (um) m_mis = m_mis + 1;
      end
      if (fl) begin
         for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      end else if (uv) begin
         i = idx_of(upc);
         if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
            m_ctr[i] = ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                          : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (ut) m_tgt[i] = utg;
         end else if (ut) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upc);
            m_tgt[i]   = utg;
            m_ctr[i]   = 2;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, ":branch_count"}, branch_count, m_br);
      chk({tag, ":mispredict_count"}, mispredict_count, m_mis);
   endtask

   // One clocked step: lookup checked against pre-update state, then counters after the edge.
   task automatic cycle(input logic [31:0] p, input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg, input logic um, input logic fl, input string tag);
      bit          ebp;
      logic [31:0] enp;
      @(negedge clock);
      pc = p; upd_valid = uv; upd_pc = upc; upd_taken = ut;
      upd_target = utg; upd_mispredict = um; flush_all = fl;
      #1;
      model_predict(p, ebp, enp);
      chk({tag, ":bp"}, {31'd0, Branch_predict}, {31'd0, ebp});
      chk({tag, ":npc"}, nextpc_predicted, enp);
      @(posedge clock);
      model_update(uv, upc, ut, utg, um, fl);
      #1;
      chk_counts(tag);
   endtask

   // Idle lookup against constants taken straight from the intended behaviour.
   task automatic look(input logic [31:0] p, input logic exp_bp, input logic [31:0] exp_np, input string tag);
      @(negedge clock);
      pc = p; upd_valid = 1'b0; flush_all = 1'b0; upd_mispredict = 1'b0;
      #1;
      chk({tag, ":bp"}, {31'd0, Branch_predict}, {31'd0, exp_bp});
      chk({tag, ":npc"}, nextpc_predicted, exp_np);
   endtask

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   initial begin
      logic [31:0] rp, rupc;
      model_reset();
      repeat (2) @(negedge clock);
      reset = 1'b0;

      look(32'h0000_0098, 1'b0, 32'h0000_009C, "reset_lookup");
      chk("reset:branch_count", branch_count, 32'd0);
      chk("reset:mispredict_count", mispredict_count, 32'd0);
      look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "wrap_pc4");

      cycle(32'h98, 1, 32'h98, 1, 32'h94, 0, 0, "alloc");
      look(32'h98, 1'b1, 32'h94, "alloc_hit");

      repeat (3) cycle(32'h98, 1, 32'h98, 1, 32'h94, 0, 0, "taken");
      look(32'h98, 1'b1, 32'h94, "sat_st");
      repeat (2) cycle(32'h98, 1, 32'h98, 0, 32'h0, 0, 0, "not_taken");
      look(32'h98, 1'b0, 32'h9C, "st_to_wnt");
      repeat (2) cycle(32'h98, 1, 32'h98, 0, 32'h0, 0, 0, "not_taken_low");
      cycle(32'h98, 1, 32'h98, 1, 32'h94, 0, 0, "snt_plus_one");
      look(32'h98, 1'b0, 32'h9C, "no_underflow");

      cycle(32'h98, 1, 32'h98, 1, 32'h94, 0, 0, "reach_wt");
      look(32'h98, 1'b1, 32'h94, "wt_predicts");
      cycle(32'hD8, 1, 32'hD8, 1, 32'h200, 0, 0, "alias_alloc");
      look(32'h98, 1'b0, 32'h9C, "alias_old_miss");
      look(32'hD8, 1'b1, 32'h200, "alias_new_hit");
      cycle(32'h118, 1, 32'h118, 0, 32'h0, 0, 0, "alias_nt_miss");
      look(32'hD8, 1'b1, 32'h200, "alias_unchanged");

      cycle(32'hA8, 1, 32'hA8, 1, 32'h300, 0, 0, "same_cycle");
      look(32'hA8, 1'b1, 32'h300, "same_cycle_next");
      cycle(32'hA8, 1, 32'h40, 1, 32'h500, 0, 1, "flush_with_upd");
      look(32'hA8, 1'b0, 32'hAC, "flush_a8");
      look(32'hD8, 1'b0, 32'hDC, "flush_d8");
      look(32'h40, 1'b0, 32'h44, "flush_no_alloc");

      @(negedge clock);
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      cycle(32'h98, 1, 32'h98, 1, 32'h94, 1, 0, "stat1");
      cycle(32'h98, 1, 32'h98, 1, 32'h94, 0, 0, "stat2");
      cycle(32'h98, 1, 32'h98, 1, 32'h94, 1, 0, "stat3");
      cycle(32'h98, 1, 32'h98, 1, 32'h94, 0, 0, "stat4");
      cycle(32'h98, 1, 32'h98, 1, 32'h94, 0, 0, "stat5");
      chk("stats:branch_count", branch_count, 32'd5);
      chk("stats:mispredict_count", mispredict_count, 32'd2);
      look(32'h98, 1'b1, 32'h94, "pre_async_hit");

      #2;
      reset = 1'b1;
      #1;
      chk("async:bp", {31'd0, Branch_predict}, 32'd0);
      chk("async:npc", nextpc_predicted, 32'h9C);
      chk("async:branch_count", branch_count, 32'd0);
      chk("async:mispredict_count", mispredict_count, 32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;

      for (int n = 0; n < 400; n++) begin
         rp   = rand_pc();
         rupc = ($urandom_range(0, 3) == 0) ? rp : rand_pc();
         cycle(rp, 1'($urandom_range(0, 9) < 7), rupc, 1'($urandom_range(0, 2) != 0),
               $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 31) == 0), "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
